// File: rtl/disp_scan_capture_if.sv
// Scan-bus and readback signals shared by the capture block and whatever drives the pins.
interface disp_scan_capture_if;
    logic [7:0] an;
    logic [7:0] sseg;
    logic [7:0] out0;
    logic [7:0] out1;
    logic [7:0] out2;
    logic [7:0] out3;
    logic       frame_valid;
    logic [3:0] digit_seen;
    logic [7:0] err_count;
    logic       stale;

    modport master (
        output an, sseg,
        input  out0, out1, out2, out3, frame_valid, digit_seen, err_count, stale
    );

    modport slave (
        input  an, sseg,
        output out0, out1, out2, out3, frame_valid, digit_seen, err_count, stale
    );
endinterface

// File: rtl/disp_scan_capture.sv
// Passive seven-segment scan monitor: dwell-filters the anode/segment bus and
// reassembles the four scanned digit patterns into coherent frames.
module disp_scan_capture #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input logic                clk,
    input logic                reset,
    disp_scan_capture_if.slave bus
);
    localparam int              TW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]      STABLE = 8'(STABLE_CYCLES);
    localparam logic [TW-1:0]   TLIM   = TW'(TIMEOUT_CYCLES);

    logic [7:0]    s_an;
    logic [7:0]    s_seg;
    logic [7:0]    run_cnt;
    logic [7:0]    run_nxt;
    logic          accept;
    logic [7:0]    staging [4];
    logic [7:0]    out_r   [4];
    logic [3:0]    digit_seen;
    logic [3:0]    seen_nxt;
    logic [7:0]    err_count;
    logic [TW-1:0] tcnt;
    logic [TW-1:0] tcnt_inc;
    logic          stale;
    logic          frame_valid;
    logic          legal;
    logic          blank;
    logic [1:0]    k;

    // The first sample after reset or after any change counts as a run of one.
    always_comb begin
        run_nxt = run_cnt;
        if ({bus.an, bus.sseg} != {s_an, s_seg})
            run_nxt = 8'd1;
        else if (run_cnt != STABLE)
            run_nxt = run_cnt + 8'd1;
    end

    always_comb begin
        legal = 1'b0;
        k     = 2'd0;
        if (s_an[7:4] == 4'hF) begin
            case (s_an[3:0])
                4'hE:    begin legal = 1'b1; k = 2'd0; end
                4'hD:    begin legal = 1'b1; k = 2'd1; end
                4'hB:    begin legal = 1'b1; k = 2'd2; end
                4'h7:    begin legal = 1'b1; k = 2'd3; end
                default: begin legal = 1'b0; k = 2'd0; end
            endcase
        end
    end

    assign blank    = (s_an == 8'hFF);
    assign seen_nxt = digit_seen | (4'b0001 << k);
    assign tcnt_inc = (tcnt == TLIM) ? tcnt : tcnt + TW'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            s_an        <= 8'hFF;
            s_seg       <= 8'hFF;
            run_cnt     <= 8'd0;
            accept      <= 1'b0;
            digit_seen  <= 4'd0;
            err_count   <= 8'd0;
            tcnt        <= '0;
            stale       <= 1'b0;
            frame_valid <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                staging[i] <= 8'hFF;
                out_r[i]   <= 8'hFF;
            end
        end else begin
            s_an        <= bus.an;
            s_seg       <= bus.sseg;
            run_cnt     <= run_nxt;
            // One pulse per dwell: only the transition into saturation fires.
            accept      <= (run_nxt == STABLE) && (run_cnt != STABLE);
            frame_valid <= 1'b0;
            if (accept && legal) begin
                staging[k] <= s_seg;
                tcnt       <= '0;
                if (&seen_nxt) begin
                    // The digit completing the frame is bypassed straight into the outputs.
                    for (int i = 0; i < 4; i++)
                        out_r[i] <= (k == 2'(i)) ? s_seg : staging[i];
                    frame_valid <= 1'b1;
                    digit_seen  <= 4'd0;
                    stale       <= 1'b0;
                end else begin
                    digit_seen <= seen_nxt;
                end
            end else begin
                tcnt <= tcnt_inc;
                if (tcnt_inc == TLIM)
                    stale <= 1'b1;
                if (accept && !blank && (err_count != 8'hFF))
                    err_count <= err_count + 8'd1;
            end
        end
    end

    assign bus.out0        = out_r[0];
    assign bus.out1        = out_r[1];
    assign bus.out2        = out_r[2];
    assign bus.out3        = out_r[3];
    assign bus.frame_valid = frame_valid;
    assign bus.digit_seen  = digit_seen;
    assign bus.err_count   = err_count;
    assign bus.stale       = stale;
endmodule

// File: doc/disp_scan_capture.md
# disp_scan_capture

Passive receiver for the multiplexed seven-segment scan bus produced by the display multiplexer. It samples the active-low anode (`an`) and segment (`sseg`) lines and rejects switching glitches with a dwell filter. It reassembles the four 8-bit digit patterns being scanned and publishes them as a coherent frame. It sits on the board side of the display path as a self-check and loopback monitor, so benches and on-chip logic can read back what is actually shown.

## Interface

Parameters:
- `STABLE_CYCLES`, default 4: number of consecutive identical samples required before a scan slot is accepted; legal range 2..255.
- `TIMEOUT_CYCLES`, default 1_000_000: cycles without a legal capture before `stale` asserts; counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `reset`  in  1: synchronous, active-low (asserted when 0).
- `an`  in  8: anode lines, active-low. `an[3:0]` are digits 0..3; `an[7:4]` must stay 1.
- `sseg`  in  8: segment pattern, active-low, `sseg[7]` = dp.
- `out0`..`out3`  out  8 each: last complete frame, raw sseg pattern per digit.
- `frame_valid`  out  1: one-cycle pulse when `out0..out3` update.
- `digit_seen`  out  4: digits captured into staging since the last frame.
- `err_count`  out  8: saturating count of illegal stable anode patterns.
- `stale`  out  1: no legal capture for `TIMEOUT_CYCLES` cycles.

## Operation

- Input stage:
  - `an` and `sseg` are registered once into `s_an` and `s_seg`; all decisions use the registered values.
  - Run counter: set to 1 when {`s_an`,`s_seg`} differs from its previous value; otherwise increment, saturating at `STABLE_CYCLES`.
- Accept event: fires in the single cycle where the run counter reaches exactly `STABLE_CYCLES`. There is one accept per dwell, so a long dwell never re-fires.
- Accept event classification on `s_an`:
  - Legal: `s_an[7:4]`=4'hF and exactly one 0 in `s_an[3:0]` at index k.
    - Write `staging[k]` <= `s_seg` and set `digit_seen[k]`.
    - Reset the timeout counter.
  - Blank: `s_an`=8'hFF. No effect (display blanking, not an error).
  - Illegal: anything else. `err_count` increments, saturating at 255. Staging and `digit_seen` are unchanged.
- Re-capture of a digit whose `digit_seen` bit is already set overwrites `staging[k]`; `digit_seen` stays set.
- Frame completion:
  - When a legal accept makes `digit_seen` all ones (counting the current write), `out0..out3` load from staging at that same edge. The current digit is bypassed in.
  - `frame_valid` is 1 for that one cycle.
  - `digit_seen` clears to 0000.
  - `stale` clears.
- Scan order is irrelevant; any order that covers all four digits completes a frame.
- Timeout:
  - The counter increments every cycle and saturates.
  - When it reaches `TIMEOUT_CYCLES`, `stale` sets and holds until the next `frame_valid`.
  - Illegal and blank accepts do not reset the counter.

## Timing

- Reset values (with `reset`=0 at an edge): `out0..out3`=8'hFF, staging=8'hFF, `frame_valid`=0, `digit_seen`=0, `err_count`=0, `stale`=0, counters=0, `s_an`=8'hFF, `s_seg`=8'hFF.
- Reset mid-operation discards partial frames and resets the error count. Reset dominates every other event in that cycle.
- Capture latency:
  - A value is driven on the pins before edge E1.
  - The first sample is at E1, and the accept fires after E(`STABLE_CYCLES`).
  - Staging or outputs are written at edge E(`STABLE_CYCLES`+1).
  - `frame_valid` is high for the cycle following that edge.
- A pin change that persists for fewer than `STABLE_CYCLES` samples produces no accept, no error, and no staging change.
- Simultaneous frame completion and timeout expiry: completion wins, so `stale` ends the cycle at 0 and the counter resets.
- All outputs are registered; there are no combinational paths from the pins.

## Test plan

Benches use `STABLE_CYCLES`=4 and `TIMEOUT_CYCLES`=64.

- Reset: hold `reset`=0 for 3 cycles with random pins -> `out0..3`=FF, `err_count`=0, `digit_seen`=0, no `frame_valid`.
- Normal scan: drive `an`=FE/FD/FB/F7 with `sseg`=55/AA/0F/F0 for 10 cycles each -> exactly one `frame_valid` pulse at dwell 4 + 5 edges, after which `out0..3`=55/AA/0F/F0 and `digit_seen`=0.
- Glitch rejection: insert a 3-cycle `an`=FC between digits, then a 4-cycle `an`=FC -> the first produces no `err_count` change, the second produces `err_count`=1, and frames are unaffected.
- Overwrite: digit 1 scanned with 11 then 22 before digits 2 and 3 -> the frame shows `out1`=22 and only one `frame_valid`.
- Timeout: hold `an`=FF for 70 cycles after reset -> `stale`=1 from the 64th counted cycle. A complete scan afterwards clears `stale` on the `frame_valid` cycle.
- Saturation and reset: 300 illegal dwells -> `err_count`=255 and held. Asserting `reset` mid-scan -> `err_count`=0, `digit_seen`=0, and the next frame requires all 4 digits.
